// File: rtl/bbs_sequencer_if.sv
// Start/done handshake between the BBS sequencer (master) and the external
// multi-cycle modular squarer (slave).
interface bbs_sequencer_if #(
  parameter int W = 16
);
  logic         mul_start;
  logic [W-1:0] mul_x;
  logic         mul_done;
  logic [W-1:0] mul_out;

  modport master (output mul_start, output mul_x, input mul_done, input mul_out);
  modport slave  (input mul_start, input mul_x, output mul_done, output mul_out);
endinterface

// File: rtl/bbs_sequencer.sv
// Blum-Blum-Shub control: steps an external squarer NBITS times per request,
// shifts in the LSB of each result and serves the number bytewise.
module bbs_sequencer #(
  parameter int  SEED_W    = 16,
  parameter int  SEED_INIT = 884,
  parameter int  NBITS     = 256,
  parameter int  TIMEOUT   = 64,
  localparam int SEL_W     = (NBITS > 8) ? $clog2(NBITS / 8) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gen_req_i,
  input  logic              seed_load_i,
  input  logic [SEED_W-1:0] seed_in_i,
  bbs_sequencer_if.master   mul,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic [SEL_W-1:0]  byte_sel_i,
  output logic [7:0]        byte_out_o,
  output logic [NBITS-1:0]  number_o
);
  localparam int CNT_W = $clog2(NBITS);
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_HARVEST = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t            state_q;
  logic [SEED_W-1:0] seed_q;
  logic [SEED_W-1:0] result_q;
  logic [SEED_W-1:0] seed_load_d;
  logic [NBITS-1:0]  number_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WD_W-1:0]   wd_q;
  logic              mul_start_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [7:0]        byte_d;
  logic [7:0]        byte_q;

  // 0 and 1 are fixed points of x^2 mod M, so they fall back to the default seed
  always_comb begin
    if (seed_in_i < SEED_W'(2)) begin
      seed_load_d = SEED_W'(SEED_INIT);
    end else begin
      seed_load_d = seed_in_i;
    end
  end

  always_comb begin
    byte_d = 8'(number_q >> {byte_sel_i, 3'b000});
  end

  // Sequencer FSM with all control outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      seed_q      <= SEED_W'(SEED_INIT);
      result_q    <= '0;
      number_q    <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gen_req_i) begin
            number_q    <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            mul_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end else if (seed_load_i) begin
            seed_q <= seed_load_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mul.mul_done) begin
            result_q <= mul.mul_out;
            state_q  <= S_HARVEST;
          end else begin
            wd_q <= wd_q + WD_W'(1);
            // abort lands err exactly TIMEOUT cycles after mul_start
            if (wd_q == WD_W'(TIMEOUT - 2)) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_HARVEST: begin
          seed_q   <= result_q;
          number_q <= {number_q[NBITS-2:0], result_q[0]};
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NBITS - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            mul_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Byte read-out register, independent of the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_q <= 8'h00;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign mul.mul_start = mul_start_q;
  assign mul.mul_x     = seed_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign byte_out_o    = byte_q;
  assign number_o      = number_q;
endmodule

// File: doc/bbs_sequencer.md
# bbs_sequencer

Control block for the Blum-Blum-Shub generator. It sequences an external multi-cycle modular squarer (x² mod M) through a start/done handshake and harvests the LSB of each squaring result. It assembles NBITS harvested bits into a number register and serves that register bytewise to the display path. It sits between the debounced "gen" button flag and the show/LED logic, and replaces free-running seed stepping with requested, counted generation runs.

## Interface
- SEED_W, 16, squarer operand width
- SEED_INIT, 884, seed value after reset or after an invalid seed load
- NBITS, 256, bits per generation run; must be a multiple of 8
- TIMEOUT, 64, maximum cycles to wait for mul_done before aborting
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- gen_req  in  1  one-cycle pulse requesting a generation run
- seed_load  in  1  load seed_in into the seed register (IDLE only)
- seed_in  in  SEED_W  seed value to load
- mul_start  out  1  one-cycle pulse starting the squarer
- mul_x  out  SEED_W  squarer operand; equals the seed register
- mul_done  in  1  one-cycle pulse; mul_out is valid in this cycle
- mul_out  in  SEED_W  squaring result
- busy  out  1  high from the cycle after gen_req is accepted until the run ends
- done  out  1  one-cycle pulse, run completed
- err  out  1  sticky timeout flag; cleared by reset or by the next accepted gen_req
- byte_sel  in  log2(NBITS/8)  byte index to read
- byte_out  out  8  number[byte_sel*8+7 : byte_sel*8], registered
- number  out  NBITS  assembled number

## Operation
- Reset values: seed=SEED_INIT; number=0; bit counter=0; watchdog=0; state=IDLE; mul_start=0; busy=0; done=0; err=0; byte_out=0.
- The FSM has five states: IDLE, ISSUE, WAIT, HARVEST, FINISH.
- IDLE:
  - gen_req=1 → clear number and err, counter=0, go to ISSUE.
  - seed_load=1 with gen_req=0 → seed=seed_in. If seed_in<2, seed=SEED_INIT instead, because 0 and 1 are fixed points.
  - seed_load and gen_req in the same cycle: gen_req wins and the load is dropped.
- ISSUE: mul_start=1 for exactly one cycle, watchdog=0, go to WAIT.
- WAIT:
  - mul_done=1 → latch mul_out, go to HARVEST.
  - Otherwise watchdog increments. When watchdog reaches TIMEOUT-1 with no mul_done: err=1, go to IDLE. number keeps its partial contents and done is not pulsed.
- HARVEST:
  - seed=latched result; number={number[NBITS-2:0], result[0]}; counter+1.
  - If counter was NBITS-1, go to FINISH; else go to ISSUE.
  - The first harvested bit ends up at number[NBITS-1].
- FINISH: done=1 for one cycle, go to IDLE.
- Ignored inputs:
  - gen_req while not in IDLE, and seed_load outside IDLE, are ignored (no queueing).
  - mul_done outside WAIT is ignored.
  - A result that arrives after a timeout abort is discarded.
- byte_out updates every cycle from the current number and byte_sel, independent of state.
- reset in any state aborts the run immediately and applies the reset values. It does not wait for the squarer.

## Timing
- gen_req at cycle t (in IDLE) → state ISSUE at t+1, busy=1 from t+1, mul_start=1 at t+1.
- With squarer latency L (mul_done L cycles after mul_start), each bit costs L+2 cycles: ISSUE→WAIT L cycles, then HARVEST.
- Per bit: mul_start at cycle s → mul_done at s+L → bit shifted in at s+L+1 → next mul_start at s+L+2.
- Whole run: done at t+1+NBITS·(L+2); busy falls in the same cycle that done is high; IDLE the next cycle.
- Timeout: err rises at mul_start+TIMEOUT; busy=0 in the same cycle.
- byte_out latency is 1 cycle from byte_sel or number change.
- mul_x is stable from mul_start until the run leaves WAIT.

## Test plan
- Reset, NBITS=8, behavioral squarer with M=40633 and L=3, single gen_req:
  - number=8'hE3, seed=37453.
  - done exactly once, 41 cycles after gen_req.
  - 8 mul_start pulses, with mul_x sequence 884, 9429, 1037, 18911, 14888, 40162, 18676, 39937.
- Run the same case again with no reset: the run continues from seed 37453 (first mul_x=37453), and number is cleared at acceptance.
- seed_load with seed_in=1 in IDLE → next run's first mul_x=884. seed_load with seed_in=1037 → the first harvested bit equals bit 1 of the 884 run's third result (18911 → 1).
- Squarer that never answers, TIMEOUT=64 → err=1 exactly 64 cycles after mul_start, busy=0, no done. The next gen_req clears err.
- gen_req pulses during busy, and stray mul_done in IDLE → no extra runs, number unchanged.
- reset asserted in WAIT of bit 5 → all outputs at reset values next cycle. A late mul_done is ignored.
- NBITS=256, byte_sel sweep 0..31 after a run → byte_out matches the corresponding slice of number, one cycle after each byte_sel change.
